// File: rtl/lamp_fpu_log_round_pack_pkg.sv
// Shared bfloat16 constants, rounding-mode enum and the log-unit round/pack function.
// Latency: none; the package holds only types, constants and a combinational function.
// Backpressure: not applicable.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_X_DW = 3;
  localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  // {exponent, fraction} of +/-Inf and of the largest finite magnitude
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F       = {8'hFF, 7'h00};
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] LAMP_MAXF_E_F = {8'hFE, 7'h7F};

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } lamp_rnd_e;

  // Occupancy of the 2-entry output buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } lamp_buf_state_e;

  // Packed result word plus the flags that travel with it
  typedef struct packed {
    logic [LAMP_FLOAT_DW-1:0] result;
    logic                     overflow;
    logic                     underflow;
    logic                     inexact;
  } lamp_rp_t;

  localparam int LAMP_RP_DW = $bits(lamp_rp_t);

  // Round {f, G, R, S}, resolve carry-out/overflow and pack the final word.
  // Priority: special passthrough, forced overflow, forced underflow, rounding overflow.
  function automatic lamp_rp_t FUNC_round_log(
    input logic                                     s,
    input logic [LAMP_FLOAT_E_DW-1:0]               e,
    input logic [LAMP_FLOAT_F_DW+LAMP_FLOAT_X_DW-1:0] f,
    input logic                                     is_to_round,
    input logic                                     is_overflow,
    input logic                                     is_underflow,
    input lamp_rnd_e                                rnd
  );
    lamp_rp_t                   res;
    logic                       lsb;
    logic                       g;
    logic                       any_low;
    logic                       inc;
    logic                       carry;
    logic [LAMP_FLOAT_F_DW-1:0] f_rnd;
    logic [LAMP_FLOAT_E_DW:0]   e_rnd;
    logic                       to_inf;
    logic                       rnd_ovf;

    lsb     = f[LAMP_FLOAT_X_DW];
    g       = f[LAMP_FLOAT_X_DW-1];
    any_low = |f[LAMP_FLOAT_X_DW-1:0];

    // RNE: round up above half, or at exactly half when L is odd
    unique case (rnd)
      RNE:     inc = g & (lsb | (|f[LAMP_FLOAT_X_DW-2:0]));
      RTZ:     inc = 1'b0;
      RUP:     inc = ~s & any_low;
      RDN:     inc = s & any_low;
      default: inc = 1'b0;
    endcase

    // A carry out of the fraction leaves f_rnd at zero and bumps the exponent
    {carry, f_rnd} = {1'b0, f[LAMP_FLOAT_X_DW +: LAMP_FLOAT_F_DW]}
                   + {{LAMP_FLOAT_F_DW{1'b0}}, inc};
    e_rnd = {1'b0, e} + {{LAMP_FLOAT_E_DW{1'b0}}, carry};

    // Reaching the all-ones exponent (or beyond) after rounding is an overflow
    rnd_ovf = e_rnd[LAMP_FLOAT_E_DW] | (&e_rnd[LAMP_FLOAT_E_DW-1:0]);

    // Modes rounding away from zero saturate to Inf, the others to max finite
    to_inf = (rnd == RNE) | ((rnd == RUP) & ~s) | ((rnd == RDN) & s);

    res = '0;
    if (!is_to_round) begin
      res.result = {s, e, f[LAMP_FLOAT_X_DW +: LAMP_FLOAT_F_DW]};
    end else if (is_overflow || (!is_underflow && rnd_ovf)) begin
      res.result   = {s, (to_inf ? INF_E_F : LAMP_MAXF_E_F)};
      res.overflow = 1'b1;
      res.inexact  = 1'b1;
    end else if (is_underflow) begin
      res.result    = {s, {(LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW){1'b0}}};
      res.underflow = 1'b1;
      res.inexact   = 1'b1;
    end else begin
      res.result  = {s, e_rnd[LAMP_FLOAT_E_DW-1:0], f_rnd};
      res.inexact = any_low;
    end
    return res;
  endfunction

endpackage

// File: rtl/lamp_fpu_log_round_pack_buf2.sv
// Two-entry valid/ready FIFO; head entry drives the outputs straight from a register.
// Latency: write in cycle N is visible at the output in N+1 when empty, else in FIFO order.
// Backpressure: i_ready low holds the head stable; o_ready drops only when both entries are full.
module lamp_fpu_buf2
  import lampFPU_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  lamp_buf_state_e r_state;
  lamp_buf_state_e w_state_nxt;
  logic [W-1:0]    r_head;
  logic [W-1:0]    r_tail;
  logic            w_acc;
  logic            w_iss;
  logic            w_load_head;
  logic            w_head_from_tail;
  logic            w_load_tail;

  // ready depends only on registered occupancy, never on i_ready
  assign o_ready = (r_state != BUF_FULL) & ~rst;
  assign o_valid = (r_state != BUF_EMPTY);
  assign o_data  = r_head;
  assign w_acc   = i_valid & o_ready;
  assign w_iss   = o_valid & i_ready;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= BUF_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next occupancy and which entry gets written this cycle
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_tail = 1'b0;
    w_load_tail      = 1'b0;
    unique case (r_state)
      BUF_EMPTY: begin
        if (w_acc) begin
          w_load_head = 1'b1;
          w_state_nxt = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (w_acc && w_iss) begin
          w_load_head = 1'b1;
        end else if (w_acc) begin
          w_load_tail = 1'b1;
          w_state_nxt = BUF_FULL;
        end else if (w_iss) begin
          w_state_nxt = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (w_iss) begin
          w_load_head      = 1'b1;
          w_head_from_tail = 1'b1;
          w_state_nxt      = BUF_ONE;
        end
      end
      default: w_state_nxt = BUF_EMPTY;
    endcase
  end

  // Entry storage; cleared on reset so the idle output reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_load_head) r_head <= w_head_from_tail ? r_tail : i_data;
      if (w_load_tail) r_tail <= i_data;
    end
  end

endmodule

// File: rtl/lamp_fpu_log_round_pack.sv
// bfloat16 log post-stage: IEEE rounding, carry/overflow handling and packing into a 16b word.
// Latency: 1 cycle from accept to valid_o with an empty buffer; FIFO order otherwise.
// Backpressure: 2-entry output buffer; ready_o drops when both entries are held by a stalled consumer.
module lamp_fpu_log_round_pack
  import lampFPU_pkg::*;
#(
  parameter int E_DW = LAMP_FLOAT_E_DW,
  parameter int F_DW = LAMP_FLOAT_F_DW,
  parameter int X_DW = LAMP_FLOAT_X_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 s_i,
  input  logic [E_DW-1:0]      e_i,
  input  logic [F_DW+X_DW-1:0] f_i,
  input  logic                 isToRound_i,
  input  logic                 isOverflow_i,
  input  logic                 isUnderflow_i,
  input  logic [1:0]           rnd_mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [E_DW+F_DW:0]   result_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 inexact_o
);

  lamp_rp_t w_rp_in;
  lamp_rp_t w_rp_out;

  // Rounding is purely combinational on the inputs; only accepted results are stored
  assign w_rp_in = FUNC_round_log(s_i, e_i, f_i, isToRound_i, isOverflow_i,
                                  isUnderflow_i, lamp_rnd_e'(rnd_mode_i));

  lamp_fpu_buf2 #(
    .W(LAMP_RP_DW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_valid (valid_i),
    .o_ready (ready_o),
    .i_data  (w_rp_in),
    .o_valid (valid_o),
    .i_ready (ready_i),
    .o_data  (w_rp_out)
  );

  assign result_o    = w_rp_out.result;
  assign overflow_o  = w_rp_out.overflow;
  assign underflow_o = w_rp_out.underflow;
  assign inexact_o   = w_rp_out.inexact;

endmodule

// File: tb/tb_lamp_fpu_log_round_pack.sv
// Randomized bench for the log round/pack stage with an arithmetic reference model and FIFO scoreboard.
module tb_lamp_fpu_log_round_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = 8'h00;
  logic [9:0]  f_i = 10'h000;
  logic        isToRound_i = 1'b1;
  logic        isOverflow_i = 1'b0;
  logic        isUnderflow_i = 1'b0;
  logic [1:0]  rnd_mode_i = 2'd0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] result_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  int total = 0;
  int bad   = 0;

  logic [18:0] exp_q[$];
  bit          clean = 1'b1;

  always #5 clk = ~clk;

  lamp_fpu_log_round_pack dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isToRound_i   (isToRound_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .rnd_mode_i    (rnd_mode_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .inexact_o     (inexact_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value arithmetic on the 10-bit fraction field; returns {word, ovf, unf, inexact}
  function automatic logic [18:0] mdl(input logic s, input logic [7:0] e, input logic [9:0] f,
                                      input logic tr, input logic ov, input logic un,
                                      input logic [1:0] rm);
    int  kept;
    int  rem;
    int  ex;
    bit  up;
    bit  inf;
    logic [7:0] eo;
    logic [6:0] fo;
    kept = int'(f) / 8;
    rem  = int'(f) % 8;
    ex   = int'(e);
    inf  = (rm == 0) || (rm == 2 && !s) || (rm == 3 && s);
    if (!tr) return {s, e, f[9:3], 3'b000};
    if (ov) return inf ? {s, 8'hFF, 7'h00, 3'b101} : {s, 8'hFE, 7'h7F, 3'b101};
    if (un) return {s, 15'd0, 3'b011};
    case (rm)
      0:       up = (rem > 4) || (rem == 4 && (kept % 2) == 1);
      1:       up = 0;
      2:       up = !s && rem != 0;
      default: up = s && rem != 0;
    endcase
    kept = kept + (up ? 1 : 0);
    if (kept == 128) begin
      kept = 0;
      ex   = ex + 1;
    end
    if (ex >= 255) return inf ? {s, 8'hFF, 7'h00, 3'b101} : {s, 8'hFE, 7'h7F, 3'b101};
    eo = ex[7:0];
    fo = kept[6:0];
    return {s, eo, fo, 2'b00, rem != 0};
  endfunction

  // Scoreboard: compare away from the edge, then advance the model across the coming edge
  always @(negedge clk) begin
    bit exp_rdy;
    bit acc;
    bit iss;
    exp_rdy = !rst && exp_q.size() < 2;
    chk("valid_o", 32'(valid_o), 32'(exp_q.size() > 0));
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    if (exp_q.size() > 0)
      chk("payload", 32'({result_o, overflow_o, underflow_o, inexact_o}), 32'(exp_q[0]));
    else if (clean)
      chk("idle_zero", 32'({result_o, overflow_o, underflow_o, inexact_o}), 32'd0);
    if (rst) begin
      exp_q.delete();
      clean = 1'b1;
    end else begin
      acc = valid_i && exp_rdy;
      iss = (exp_q.size() > 0) && ready_i;
      if (iss) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(mdl(s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i, rnd_mode_i));
        clean = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present the current inputs until accepted (bounded)
  task automatic send();
    bit done;
    done = 0;
    valid_i = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (ready_o) done = 1;
      step();
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL send_timeout: ready_o stayed 0 expected 1");
    end
    valid_i = 1'b0;
  endtask

  task automatic set_in(input logic s, input logic [7:0] e, input logic [9:0] f,
                        input logic tr, input logic ov, input logic un, input logic [1:0] rm);
    s_i = s; e_i = e; f_i = f;
    isToRound_i = tr; isOverflow_i = ov; isUnderflow_i = un; rnd_mode_i = rm;
  endtask

  initial begin
    // Pin the reference model to hand-computed words
    chk("pin_rne_tie_even", 32'(mdl(0, 8'h7F, 10'b1000000_100, 1, 0, 0, 0)), 32'({16'h3FC0, 3'b001}));
    chk("pin_rne_tie_odd",  32'(mdl(0, 8'h7F, 10'b1000001_100, 1, 0, 0, 0)), 32'({16'h3FC2, 3'b001}));
    chk("pin_carry_rne",    32'(mdl(0, 8'h7F, 10'b1111111_110, 1, 0, 0, 0)), 32'({16'h4000, 3'b001}));
    chk("pin_carry_rtz",    32'(mdl(0, 8'h7F, 10'b1111111_110, 1, 0, 0, 1)), 32'({16'h3FFF, 3'b001}));
    chk("pin_ovf_rne",      32'(mdl(0, 8'hFE, 10'b1111111_111, 1, 1, 0, 0)), 32'({16'h7F80, 3'b101}));
    chk("pin_ovf_rtz",      32'(mdl(0, 8'hFE, 10'b1111111_111, 1, 1, 0, 1)), 32'({16'h7F7F, 3'b101}));
    chk("pin_ovf_neg_rup",  32'(mdl(1, 8'hFE, 10'b1111111_111, 1, 1, 0, 2)), 32'({16'hFF7F, 3'b101}));
    chk("pin_rnd_ovf_rne",  32'(mdl(0, 8'hFE, 10'b1111111_111, 1, 0, 0, 0)), 32'({16'h7F80, 3'b101}));
    chk("pin_special_nan",  32'(mdl(0, 8'hFF, 10'b1000000_101, 0, 1, 1, 0)), 32'({16'h7FC0, 3'b000}));
    chk("pin_underflow",    32'(mdl(1, 8'h10, 10'b0101010_101, 1, 0, 1, 0)), 32'({16'h8000, 3'b011}));
    chk("pin_ovf_over_unf", 32'(mdl(1, 8'h10, 10'b0000000_000, 1, 1, 1, 1)), 32'({16'hFF7F, 3'b101}));

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed vectors through the DUT
    ready_i = 1'b1;
    set_in(0, 8'h7F, 10'b1000000_100, 1, 0, 0, 0); send();
    set_in(0, 8'h7F, 10'b1000001_100, 1, 0, 0, 0); send();
    set_in(0, 8'h7F, 10'b1111111_110, 1, 0, 0, 0); send();
    set_in(0, 8'h7F, 10'b1111111_110, 1, 0, 0, 1); send();
    set_in(0, 8'hFE, 10'b1111111_111, 1, 1, 0, 0); send();
    set_in(0, 8'hFE, 10'b1111111_111, 1, 1, 0, 1); send();
    set_in(1, 8'hFE, 10'b1111111_111, 1, 1, 0, 2); send();
    set_in(0, 8'hFE, 10'b1111111_111, 1, 0, 0, 0); send();
    set_in(0, 8'hFF, 10'b1000000_011, 0, 1, 0, 3); send();
    set_in(1, 8'h22, 10'b0000011_001, 1, 0, 1, 0); send();
    repeat (3) step();

    // Backpressure: two accepts fill the buffer, the third waits
    ready_i = 1'b0;
    set_in(0, 8'h40, 10'b0000001_000, 1, 0, 0, 0); send();
    set_in(0, 8'h41, 10'b0000010_000, 1, 0, 0, 0); send();
    set_in(0, 8'h42, 10'b0000011_000, 1, 0, 0, 0);
    valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("full_ready_low", 32'(ready_o), 32'd0);
      step();
    end
    ready_i = 1'b1;
    send();
    repeat (4) step();

    // Reset while both entries are held
    ready_i = 1'b0;
    set_in(1, 8'h50, 10'b1010101_010, 1, 0, 0, 2); send();
    set_in(0, 8'h51, 10'b0101010_101, 1, 0, 0, 3); send();
    rst = 1'b1;
    step();
    chk("rst_valid_low", 32'(valid_o), 32'd0);
    chk("rst_ready_low", 32'(ready_o), 32'd0);
    rst = 1'b0;
    ready_i = 1'b1;
    step();
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    repeat (3) step();

    // Random traffic with random stalls and occasional resets
    for (int n = 0; n < 3000; n++) begin
      s_i           = 1'($urandom);
      e_i           = ($urandom % 4 == 0) ? 8'(8'hFC + $urandom % 4) : 8'($urandom);
      f_i           = ($urandom % 4 == 0) ? 10'(10'h3F8 + $urandom % 8) : 10'($urandom);
      isToRound_i   = ($urandom % 5 != 0);
      isOverflow_i  = ($urandom % 10 == 0);
      isUnderflow_i = ($urandom % 10 == 0);
      rnd_mode_i    = 2'($urandom);
      valid_i       = ($urandom % 4 != 0);
      ready_i       = ($urandom % 3 != 0);
      rst           = ($urandom % 250 == 0);
      step();
    end
    rst = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
